// File: rtl/hdlc_rx_frame_buffer_if.sv
// Byte-wide stream bundle: valid/ready/last/data.
// The master drives valid, last and data; the slave drives ready.
interface hdlc_rx_frame_buffer_if;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic [7:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/hdlc_rx_frame_buffer.sv
// HDLC receive frame buffer: stores each incoming frame and checks its
// CRC-16/X.25 FCS. Good frames are forwarded on a backpressured byte stream,
// optionally without the FCS. Bad, runt and overflowed frames are rewound
// out of the buffer, and each outcome is counted.
module hdlc_rx_frame_buffer #(
  parameter int unsigned DATA_DEPTH  = 2048,
  parameter int unsigned FRAME_DEPTH = 16,
  parameter bit          CHECK_FCS   = 1'b1,
  parameter bit          STRIP_FCS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  hdlc_rx_frame_buffer_if.slave  in_stream,
  hdlc_rx_frame_buffer_if.master out_stream,
  output logic [15:0]            frames_ok,
  output logic [15:0]            frames_bad,
  output logic [15:0]            frames_drop,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam int unsigned FW = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
  localparam logic [AW:0] BUF_FULL_LVL = (AW+1)'(DATA_DEPTH);
  localparam logic [FW:0] LF_FULL_LVL  = (FW+1)'(FRAME_DEPTH);
  localparam logic [AW:0] MIN_LEN      = (AW+1)'(3);
  localparam logic [AW:0] FCS_LEN      = (AW+1)'(2);
  localparam logic [15:0] CRC_GOOD     = 16'hF0B8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    SKIP
  } rd_state_t;

  // Reflected CRC-16 (poly 0x8408), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // Storage
  logic [7:0]  mem    [DATA_DEPTH];
  logic [AW:0] lf_mem [2**FW];
  logic [7:0]  rdata;

  // Write side state
  logic [AW:0] wp;
  logic [AW:0] fstart;
  logic [AW:0] cnt;
  logic [15:0] crc;
  logic        ovf;

  // End-of-frame decision pending (captured on tlast, resolved next cycle)
  logic        pend_valid;
  logic        pend_ovf;
  logic        pend_crc_ok;
  logic [AW:0] pend_len;
  logic [AW:0] pend_start;

  // Length FIFO pointers
  logic [FW:0] lf_wp;
  logic [FW:0] lf_rp;

  // Read side state
  rd_state_t   state;
  logic [AW:0] rp;
  logic [AW:0] rem;
  logic        out_valid;
  logic        out_last;

  // Combinational helpers
  logic        lf_full;
  logic        lf_empty;
  logic        pend_drop;
  logic        pend_bad;
  logic        pend_commit;
  logic        rewind;
  logic [AW:0] eff_wp;
  logic [AW:0] eff_fstart;
  logic        buf_full;
  logic        byte_in;
  logic        store;
  logic        set_ovf;
  logic [15:0] crc_next;
  logic [AW:0] wp_next;
  logic        hs;
  logic [AW:0] raddr;
  logic [AW:0] lf_head;
  logic [AW:0] emit_len;

  assign in_stream.tready  = 1'b1;
  assign out_stream.tvalid = out_valid;
  assign out_stream.tlast  = out_last;
  assign out_stream.tdata  = rdata;

  // Resolve the pending end-of-frame decision and derive the write address.
  // A rewind and a new first byte can land in the same cycle: the byte is
  // written at the rewind target, so the rewind never clobbers it.
  always_comb begin
    lf_full     = (lf_wp - lf_rp) == LF_FULL_LVL;
    lf_empty    = (lf_wp == lf_rp);
    pend_drop   = pend_valid && (pend_ovf || lf_full);
    pend_bad    = pend_valid && !pend_drop &&
                  ((pend_len < MIN_LEN) || (CHECK_FCS && !pend_crc_ok));
    pend_commit = pend_valid && !pend_drop && !pend_bad;
    rewind      = pend_drop || pend_bad;
    eff_wp      = rewind ? pend_start : wp;
    eff_fstart  = rewind ? pend_start : fstart;
    buf_full    = (eff_wp - rp) == BUF_FULL_LVL;
    byte_in     = in_stream.tvalid;
    store       = byte_in && !ovf && !buf_full;
    set_ovf     = byte_in && !ovf && buf_full;
    crc_next    = crc16_byte(crc, in_stream.tdata);
    wp_next     = eff_wp + {{AW{1'b0}}, store};
    overflow    = pend_drop;
  end

  // Read address and length FIFO head for the output side.
  always_comb begin
    hs       = out_valid && out_stream.tready;
    raddr    = (state == STREAM && hs) ? (rp + 1'b1) : rp;
    lf_head  = lf_mem[lf_rp[FW-1:0]];
    emit_len = STRIP_FCS ? (lf_head - FCS_LEN) : lf_head;
  end

  // Byte RAM write port.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[eff_wp[AW-1:0]] <= in_stream.tdata;
    end
  end

  // Byte RAM read port; re-reading rp while stalled keeps tdata stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr[AW-1:0]];
    end
  end

  // Length FIFO storage.
  always_ff @(posedge clk) begin
    if (pend_commit) begin
      lf_mem[lf_wp[FW-1:0]] <= pend_len;
    end
  end

  // Write side: store bytes, run the CRC, capture the end-of-frame result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      fstart      <= '0;
      cnt         <= '0;
      crc         <= '1;
      ovf         <= 1'b0;
      pend_valid  <= 1'b0;
      pend_ovf    <= 1'b0;
      pend_crc_ok <= 1'b0;
      pend_len    <= '0;
      pend_start  <= '0;
    end else begin
      wp <= wp_next;
      if (byte_in && in_stream.tlast) begin
        pend_valid  <= 1'b1;
        pend_ovf    <= ovf || set_ovf;
        pend_crc_ok <= (crc_next == CRC_GOOD);
        pend_len    <= cnt + {{AW{1'b0}}, store};
        pend_start  <= eff_fstart;
        fstart      <= wp_next;
        cnt         <= '0;
        crc         <= '1;
        ovf         <= 1'b0;
      end else begin
        pend_valid <= 1'b0;
        fstart     <= eff_fstart;
        if (store) begin
          cnt <= cnt + 1'b1;
          crc <= crc_next;
        end
        if (set_ovf) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Length FIFO push and outcome counters (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lf_wp       <= '0;
      frames_ok   <= '0;
      frames_bad  <= '0;
      frames_drop <= '0;
    end else begin
      if (pend_commit) begin
        lf_wp <= lf_wp + 1'b1;
        if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      end
      if (pend_bad && frames_bad != 16'hFFFF) begin
        frames_bad <= frames_bad + 16'd1;
      end
      if (pend_drop && frames_drop != 16'hFFFF) begin
        frames_drop <= frames_drop + 16'd1;
      end
    end
  end

  // Read FSM: pop a length, stream the frame, then skip the FCS bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rp        <= '0;
      rem       <= '0;
      lf_rp     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!lf_empty) state <= LOAD;
        end
        LOAD: begin
          lf_rp     <= lf_rp + 1'b1;
          rem       <= emit_len;
          out_valid <= 1'b1;
          out_last  <= (emit_len == (AW+1)'(1));
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            rp <= rp + 1'b1;
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= STRIP_FCS ? SKIP : IDLE;
            end else begin
              rem      <= rem - 1'b1;
              out_last <= (rem == (AW+1)'(2));
            end
          end
        end
        SKIP: begin
          rp    <= rp + FCS_LEN;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_rx_frame_buffer.sv
// Directed bench for hdlc_rx_frame_buffer: good/bad/runt frames, overflow,
// back-to-back frames under random backpressure, and reset mid-stream.
module tb_hdlc_rx_frame_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdlc_rx_frame_buffer_if in_bus ();
  hdlc_rx_frame_buffer_if out_bus ();
  hdlc_rx_frame_buffer_if in_bus2 ();
  hdlc_rx_frame_buffer_if out_bus2 ();

  logic [15:0] frames_ok, frames_bad, frames_drop;
  logic        overflow;
  logic [15:0] frames_ok2, frames_bad2, frames_drop2;
  logic        overflow2;

  hdlc_rx_frame_buffer #(
    .DATA_DEPTH (64),
    .FRAME_DEPTH(16),
    .CHECK_FCS  (1'b1),
    .STRIP_FCS  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_stream  (in_bus),
    .out_stream (out_bus),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad),
    .frames_drop(frames_drop),
    .overflow   (overflow)
  );

  hdlc_rx_frame_buffer #(
    .DATA_DEPTH (64),
    .FRAME_DEPTH(16),
    .CHECK_FCS  (1'b0),
    .STRIP_FCS  (1'b1)
  ) dut_nofcs (
    .clk        (clk),
    .rst        (rst),
    .in_stream  (in_bus2),
    .out_stream (out_bus2),
    .frames_ok  (frames_ok2),
    .frames_bad (frames_bad2),
    .frames_drop(frames_drop2),
    .overflow   (overflow2)
  );

  assign out_bus2.tready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [8:0] rx_q  [$];
  logic [8:0] rx2_q [$];
  logic [7:0] frm   [$];
  int         ovf_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;
  bit         rand_rdy = 1'b0;
  logic       fixed_rdy = 1'b1;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [15:0] crc_upd(logic [15:0] c, logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Append the FCS (complemented CRC, low byte first) to frm.
  function automatic void add_fcs();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
  endfunction

  // Ready generator: fixed level or 50% random, updated after each edge.
  always @(posedge clk) begin
    #2;
    out_bus.tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end

  // Output monitor: log handshakes, verify hold-while-stalled, count pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_bus.tvalid}, 32'd1);
        chk("hold_word", {23'd0, out_bus.tlast, out_bus.tdata}, {23'd0, prev_word});
      end
      if (out_bus.tvalid && out_bus.tready) rx_q.push_back({out_bus.tlast, out_bus.tdata});
      if (out_bus2.tvalid && out_bus2.tready) rx2_q.push_back({out_bus2.tlast, out_bus2.tdata});
      if (overflow) ovf_cnt++;
      prev_stall = out_bus.tvalid && !out_bus.tready;
      prev_word  = {out_bus.tlast, out_bus.tdata};
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(logic [7:0] b, logic l, bit which);
    if (which) begin
      in_bus2.tvalid = 1'b1; in_bus2.tdata = b; in_bus2.tlast = l;
    end else begin
      in_bus.tvalid = 1'b1; in_bus.tdata = b; in_bus.tlast = l;
    end
    tick(1);
    in_bus.tvalid = 1'b0; in_bus.tlast = 1'b0;
    in_bus2.tvalid = 1'b0; in_bus2.tlast = 1'b0;
  endtask

  task automatic send_frame(bit which);
    for (int i = 0; i < frm.size(); i++) put(frm[i], i == frm.size() - 1, which);
  endtask

  task automatic wait_rx(int n, int budget, string tag);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    tick(2);
    chk({tag, "_rst_valid"}, {31'd0, out_bus.tvalid}, 32'd0);
    chk({tag, "_rst_last"}, {31'd0, out_bus.tlast}, 32'd0);
    chk({tag, "_rst_data"}, {24'd0, out_bus.tdata}, 32'd0);
    chk({tag, "_rst_ok"}, {16'd0, frames_ok}, 32'd0);
    chk({tag, "_rst_bad"}, {16'd0, frames_bad}, 32'd0);
    chk({tag, "_rst_drop"}, {16'd0, frames_drop}, 32'd0);
    chk({tag, "_rst_ovf"}, {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick(1);
    rx_q.delete();
    rx2_q.delete();
    ovf_cnt = 0;
  endtask

  task automatic frame_123();
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    frm.push_back(8'h6E);
    frm.push_back(8'h90);
  endtask

  task automatic check_123(int base, string tag);
    for (int i = 0; i < 9; i++) begin
      chk(tag, {23'd0, rx_q[base+i]}, {23'd0, (i == 8), 8'h31 + 8'(i)});
    end
  endtask

  initial begin
    in_bus.tvalid = 1'b0;  in_bus.tlast = 1'b0;  in_bus.tdata = '0;
    in_bus2.tvalid = 1'b0; in_bus2.tlast = 1'b0; in_bus2.tdata = '0;

    // Test 1: "123456789" + FCS 6E 90; latency and content
    do_reset("t1");
    frame_123();
    send_frame(1'b0);
    tick(3);
    chk("t1_valid_by_T4", {31'd0, out_bus.tvalid}, 32'd1);
    wait_rx(9, 50, "t1_count");
    check_123(0, "t1_byte");
    tick(10);
    chk("t1_no_extra", rx_q.size(), 9);
    chk("t1_ok", {16'd0, frames_ok}, 32'd1);
    chk("t1_bad", {16'd0, frames_bad}, 32'd0);

    // Test 2: corrupted frame followed back-to-back by the good frame
    do_reset("t2");
    frame_123();
    frm[4] = 8'h36;
    send_frame(1'b0);
    frame_123();
    send_frame(1'b0);
    wait_rx(9, 50, "t2_count");
    check_123(0, "t2_byte");
    tick(10);
    chk("t2_no_extra", rx_q.size(), 9);
    chk("t2_bad", {16'd0, frames_bad}, 32'd1);
    chk("t2_ok", {16'd0, frames_ok}, 32'd1);

    // Test 3: runts of 1 and 2 bytes; then 3-byte frame with FCS check off
    do_reset("t3");
    frm.delete(); frm.push_back(8'h7E);
    send_frame(1'b0);
    tick(2);
    frm.delete(); frm.push_back(8'h11); frm.push_back(8'h22);
    send_frame(1'b0);
    tick(15);
    chk("t3_bad", {16'd0, frames_bad}, 32'd2);
    chk("t3_ok", {16'd0, frames_ok}, 32'd0);
    chk("t3_no_out", rx_q.size(), 0);
    frm.delete(); frm.push_back(8'hA5); frm.push_back(8'h5A); frm.push_back(8'h3C);
    send_frame(1'b1);
    tick(15);
    chk("t3_nofcs_count", rx2_q.size(), 1);
    if (rx2_q.size() > 0) chk("t3_nofcs_byte", {23'd0, rx2_q[0]}, {23'd0, 9'h1A5});
    chk("t3_nofcs_ok", {16'd0, frames_ok2}, 32'd1);

    // Test 4: two 40-byte frames into a 64-byte buffer with tready low
    do_reset("t4");
    fixed_rdy = 1'b0;
    tick(2);
    frm.delete();
    for (int i = 0; i < 38; i++) frm.push_back(8'h10 + 8'(i));
    add_fcs();
    send_frame(1'b0);
    tick(5);
    frm.delete();
    for (int i = 0; i < 38; i++) frm.push_back(8'h80 + 8'(i));
    add_fcs();
    send_frame(1'b0);
    tick(10);
    chk("t4_ovf_pulses", ovf_cnt, 1);
    chk("t4_drop", {16'd0, frames_drop}, 32'd1);
    chk("t4_ok", {16'd0, frames_ok}, 32'd1);
    chk("t4_stalled_none", rx_q.size(), 0);
    chk("t4_stalled_valid", {31'd0, out_bus.tvalid}, 32'd1);
    chk("t4_stalled_data", {24'd0, out_bus.tdata}, 32'h10);
    fixed_rdy = 1'b1;
    wait_rx(38, 200, "t4_count");
    for (int i = 0; i < 38 && i < rx_q.size(); i++) begin
      chk("t4_byte", {23'd0, rx_q[i]}, {23'd0, (i == 37), 8'h10 + 8'(i)});
    end
    tick(20);
    chk("t4_no_extra", rx_q.size(), 38);

    // Test 5: back-to-back good frames, random backpressure
    do_reset("t5");
    rand_rdy = 1'b1;
    frame_123();
    send_frame(1'b0);
    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(8'hC0 + 8'(i));
    add_fcs();
    send_frame(1'b0);
    wait_rx(17, 400, "t5_count");
    if (rx_q.size() >= 17) begin
      check_123(0, "t5_byte_a");
      for (int i = 0; i < 8; i++) begin
        chk("t5_byte_b", {23'd0, rx_q[9+i]}, {23'd0, (i == 7), 8'hC0 + 8'(i)});
      end
    end
    chk("t5_ok", {16'd0, frames_ok}, 32'd2);
    rand_rdy = 1'b0;
    fixed_rdy = 1'b1;
    tick(3);

    // Test 6: reset during STREAM, then a fresh frame
    do_reset("t6");
    frame_123();
    send_frame(1'b0);
    wait_rx(3, 50, "t6_pre_count");
    rst = 1'b1;
    tick(1);
    chk("t6_mid_valid", {31'd0, out_bus.tvalid}, 32'd0);
    chk("t6_mid_last", {31'd0, out_bus.tlast}, 32'd0);
    chk("t6_mid_data", {24'd0, out_bus.tdata}, 32'd0);
    chk("t6_mid_ok", {16'd0, frames_ok}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    rx_q.delete();
    tick(10);
    chk("t6_no_residue", rx_q.size(), 0);
    frame_123();
    send_frame(1'b0);
    wait_rx(9, 50, "t6_count");
    check_123(0, "t6_byte");
    tick(20);
    chk("t6_no_extra", rx_q.size(), 9);
    chk("t6_ok", {16'd0, frames_ok}, 32'd1);
    chk("t6_bad", {16'd0, frames_bad}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_frame_buffer.md
Name: hdlc_rx_frame_buffer

Overview:
- Sits directly downstream of the HDLC command receiver and consumes its byte stream (tvalid/tlast/tdata, no backpressure).
- Buffers each received frame and checks the HDLC FCS (CRC-16/X.25) over the whole frame.
- Forwards only good frames, optionally with the 2 FCS bytes stripped, on an AXI-stream master with full tready backpressure toward the DMA/PS.
- Discards bad, runt and overflowed frames and counts every outcome.

Parameters:
- DATA_DEPTH, 2048: byte buffer depth; power of 2, at least 64.
- FRAME_DEPTH, 16: committed-frame length FIFO depth; power of 2.
- CHECK_FCS, 1: 1 = discard frames whose CRC residue is not 0xF0B8; 0 = accept any frame of length ≥3.
- STRIP_FCS, 1: 1 = the last 2 bytes of each frame are not forwarded; 0 = forward all bytes.

Ports:
- clk  in  1  system clock; same clock as the HDLC receiver.
- rst  in  1  asynchronous, active-high reset.
- in_tvalid  in  1  byte valid from the HDLC receiver; the block never stalls it.
- in_tlast  in  1  last byte of frame (FCS high byte).
- in_tdata  in  8  received byte.
- out_tvalid  out  1  AXI-stream valid.
- out_tready  in  1  AXI-stream ready.
- out_tlast  out  1  last forwarded byte of frame.
- out_tdata  out  8  forwarded byte.
- frames_ok  out  16  count of committed frames; saturates at 0xFFFF.
- frames_bad  out  16  count of frames dropped for FCS error or runt; saturates.
- frames_drop  out  16  count of frames dropped for overflow; saturates.
- overflow  out  1  one-cycle pulse when a frame is dropped for overflow.

Behaviour:
- Reset:
  - All outputs 0; all pointers, counters and CRC state cleared; state IDLE.
  - A reset mid-frame or mid-output loses all buffered data; no partial tlast is issued.
- Write side, per accepted byte (in_tvalid=1):
  - Byte is stored at wp; wp increments; the frame byte count increments.
  - CRC update uses reflected poly 0x8408, LSB first, init 0xFFFF at frame start.
  - Pointers are log2(DATA_DEPTH)+1 bits wide; full when wp−rp == DATA_DEPTH.
- Buffer full:
  - A byte arriving while full is not stored; the current frame is flagged ovf.
  - Later bytes of that frame are ignored until tlast.
- End of frame: tlast accepted in cycle T; the decision is registered in T+1.
  - Discard if ovf, or the length FIFO is full at T+1. Action: wp rewinds to the frame start; frames_drop+1; overflow pulses in T+1.
  - Otherwise discard if length<3, or CHECK_FCS and CRC≠0xF0B8. Action: wp rewinds to the frame start; frames_bad+1.
  - Otherwise commit: push length to the length FIFO; the frame start moves to wp; frames_ok+1.
- A byte arriving in T+1 belongs to the next frame. Its CRC restarts from 0xFFFF and it is written at the post-decision wp. A rewind must not overwrite it: the rewind target plus the new byte is handled in the same cycle.
- Read FSM:
  - IDLE: length FIFO non-empty → LOAD.
  - LOAD: pop length; emit count = len−2 if STRIP_FCS, else len. Issue the first synchronous RAM read → STREAM.
  - STREAM: out_tvalid=1. out_tdata/out_tlast are held stable while out_tready=0. On each handshake rp++ and the next byte is presented the following cycle with no bubble (prefetch register). out_tlast=1 on the final emitted byte; its handshake → SKIP if STRIP_FCS, else IDLE.
  - SKIP: rp += 2 in one cycle → IDLE.
- Latency: a committed frame with the read FSM idle gives out_tvalid at T+4 at the latest.
- Throughput: 1 byte/cycle while out_tready=1.
- Inter-frame gap: ≤3 idle cycles on the output.
- Simultaneous write, read, commit and rewind are all legal in the same cycle.
- Freed space (rp advance) is visible to the full check in the next cycle.
- Counters saturate and never wrap.

Test Plan:
1. Frame 0x31..0x39 + 0x6E,0x90 with tlast on 0x90, out_tready=1 → out emits 0x31..0x39, tlast on 0x39; frames_ok=1, frames_bad=0.
2. Same frame with 0x35 corrupted to 0x36 → nothing emitted; frames_bad=1. The next good frame (test 1 bytes) is emitted intact.
3. Runt frames of 1 and 2 bytes → frames_bad=2; no output. Repeat with CHECK_FCS=0 and an arbitrary 3-byte frame → 1 byte emitted.
4. DATA_DEPTH=64, out_tready=0, good 40-byte frame then 40-byte frame → second frame overflows; overflow pulse once; frames_drop=1. Raise out_tready → only the first frame (38 bytes) is emitted.
5. Back-to-back good frames (next frame's first byte arrives at T+1), random out_tready 50% → byte-exact output; out_tdata stable while stalled; frames_ok=2.
6. Assert rst mid-STREAM, then send test 1 frame → outputs 0 during reset; only the new frame is emitted; counters restart from 0.
